// File: rtl/exe_alu_stage_if.sv
// ============================================================================
//  Module  : exe_alu_stage_if
//  Brief   : EXE-stage operand/control bundle in, EXE/MEM register bundle out.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface exe_alu_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
);
   logic              in_valid;
   logic [3:0]        exe_cmd;
   logic              s_bit;
   logic [DATA_W-1:0] val_1;
   logic [DATA_W-1:0] val_2;
   logic [DATA_W-1:0] st_val_in;
   logic [REG_AW-1:0] dest_in;
   logic              wb_en_in;
   logic              mem_r_en_in;
   logic              mem_w_en_in;
   logic              freeze;
   logic              flush;

   logic              out_valid;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] st_val;
   logic [REG_AW-1:0] dest;
   logic              wb_en;
   logic              mem_r_en;
   logic              mem_w_en;
   logic [3:0]        sr;

   modport master (
      output in_valid, exe_cmd, s_bit, val_1, val_2, st_val_in, dest_in,
             wb_en_in, mem_r_en_in, mem_w_en_in, freeze, flush,
      input  out_valid, alu_result, st_val, dest, wb_en, mem_r_en, mem_w_en, sr
   );

   modport slave (
      input  in_valid, exe_cmd, s_bit, val_1, val_2, st_val_in, dest_in,
             wb_en_in, mem_r_en_in, mem_w_en_in, freeze, flush,
      output out_valid, alu_result, st_val, dest, wb_en, mem_r_en, mem_w_en, sr
   );
endinterface

`default_nettype wire

// File: rtl/exe_alu_stage.sv
// ============================================================================
//  Module  : exe_alu_stage
//  Brief   : Execute-stage ALU with NZCV status register and EXE/MEM register.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module exe_alu_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4
) (
   input  wire              clk,
   input  wire              rst_n,
   exe_alu_stage_if.slave   bus
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   logic [DATA_W:0]   w_wide;
   logic [DATA_W-1:0] w_res;
   logic              w_c;
   logic              w_v;
   logic [3:0]        w_nzcv;
   logic              w_a_msb;
   logic              w_b_msb;

   logic              valid_q,  valid_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] st_val_q, st_val_d;
   logic [REG_AW-1:0] dest_q,   dest_d;
   logic              wb_en_q,  wb_en_d;
   logic              mem_r_q,  mem_r_d;
   logic              mem_w_q,  mem_w_d;
   logic [3:0]        sr_q,     sr_d;

   assign w_a_msb = bus.val_1[DATA_W-1];
   assign w_b_msb = bus.val_2[DATA_W-1];

   // Carry-in for ADC/SBC comes from the registered flags, never this cycle's.
   always_comb begin
      w_wide = '0;
      w_res  = '0;
      w_c    = sr_q[1];
      w_v    = sr_q[0];
      case (bus.exe_cmd)
         CMD_MOV: w_res = bus.val_2;
         CMD_MVN: w_res = ~bus.val_2;
         CMD_ADD, CMD_ADC: begin
            w_wide = {1'b0, bus.val_1} + {1'b0, bus.val_2}
                   + {{DATA_W{1'b0}}, (bus.exe_cmd == CMD_ADC) & sr_q[1]};
            w_res  = w_wide[DATA_W-1:0];
            w_c    = w_wide[DATA_W];
            w_v    = (w_a_msb == w_b_msb) && (w_res[DATA_W-1] != w_a_msb);
         end
         CMD_SUB, CMD_SBC: begin
            w_wide = {1'b0, bus.val_1} - {1'b0, bus.val_2}
                   - {{DATA_W{1'b0}}, (bus.exe_cmd == CMD_SBC) & ~sr_q[1]};
            w_res  = w_wide[DATA_W-1:0];
            w_c    = ~w_wide[DATA_W];
            w_v    = (w_a_msb != w_b_msb) && (w_res[DATA_W-1] != w_a_msb);
         end
         CMD_AND: w_res = bus.val_1 & bus.val_2;
         CMD_ORR: w_res = bus.val_1 | bus.val_2;
         CMD_EOR: w_res = bus.val_1 ^ bus.val_2;
         default: w_res = '0;
      endcase
      w_nzcv = {w_res[DATA_W-1], (w_res == '0), w_c, w_v};
   end

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      st_val_d = st_val_q;
      dest_d   = dest_q;
      wb_en_d  = wb_en_q;
      mem_r_d  = mem_r_q;
      mem_w_d  = mem_w_q;
      sr_d     = sr_q;
      if (!bus.freeze) begin
         if (bus.flush) begin
            valid_d = 1'b0;
            wb_en_d = 1'b0;
            mem_r_d = 1'b0;
            mem_w_d = 1'b0;
         end else begin
            valid_d  = bus.in_valid;
            result_d = w_res;
            st_val_d = bus.st_val_in;
            dest_d   = bus.dest_in;
            wb_en_d  = bus.wb_en_in    & bus.in_valid;
            mem_r_d  = bus.mem_r_en_in & bus.in_valid;
            mem_w_d  = bus.mem_w_en_in & bus.in_valid;
            // Loads/stores use the adder for addressing only; flags stay put.
            if (bus.in_valid && bus.s_bit && !bus.mem_r_en_in && !bus.mem_w_en_in)
               sr_d = w_nzcv;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         st_val_q <= '0;
         dest_q   <= '0;
         wb_en_q  <= 1'b0;
         mem_r_q  <= 1'b0;
         mem_w_q  <= 1'b0;
         sr_q     <= 4'b0000;
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         st_val_q <= st_val_d;
         dest_q   <= dest_d;
         wb_en_q  <= wb_en_d;
         mem_r_q  <= mem_r_d;
         mem_w_q  <= mem_w_d;
         sr_q     <= sr_d;
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.alu_result = result_q;
   assign bus.st_val     = st_val_q;
   assign bus.dest       = dest_q;
   assign bus.wb_en      = wb_en_q;
   assign bus.mem_r_en   = mem_r_q;
   assign bus.mem_w_en   = mem_w_q;
   assign bus.sr         = sr_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_alu_stage.sv
// ============================================================================
//  Module  : tb_exe_alu_stage
//  Brief   : Scoreboard bench for exe_alu_stage.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exe_alu_stage;

   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exe_alu_stage_if #(.DATA_W(32), .REG_AW(4)) bus ();

   exe_alu_stage #(.DATA_W(32), .REG_AW(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] res;
      logic [31:0] st;
      logic [3:0]  dest;
      logic        wb;
      logic        mr;
      logic        mw;
      logic [3:0]  sr;
      logic        dchk;
   } exp_t;

   exp_t m;
   exp_t sb_q[$];
   int   n_checks;
   int   n_errors;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference ALU: returns {result, N, Z, C, V}.
   function automatic logic [35:0] model_alu(input logic [3:0] cmd, input logic [31:0] a,
                                             input logic [31:0] b, input logic [3:0] sr);
      logic [31:0] r;
      logic        c;
      logic        v;
      logic [32:0] t;
      logic        brw;
      c = sr[1];
      v = sr[0];
      r = 32'h0;
      case (cmd)
         4'b0001: r = b;
         4'b1001: r = ~b;
         4'b0010, 4'b0011: begin
            t = 33'(a) + 33'(b) + ((cmd == 4'b0011 && sr[1]) ? 33'd1 : 33'd0);
            r = t[31:0];
            c = t[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'b0100, 4'b0101: begin
            brw = (cmd == 4'b0101) && !sr[1];
            r   = a - b - (brw ? 32'd1 : 32'd0);
            c   = (33'(a) >= 33'(b) + (brw ? 33'd1 : 33'd0));
            v   = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'b0110: r = a & b;
         4'b0111: r = a | b;
         4'b1000: r = a ^ b;
         default: r = 32'h0;
      endcase
      return {r, r[31], (r == 32'h0), c, v};
   endfunction

   task automatic compare_out(input exp_t e);
      check("out_valid", 32'(bus.out_valid), 32'(e.v));
      check("wb_en",     32'(bus.wb_en),     32'(e.wb));
      check("mem_r_en",  32'(bus.mem_r_en),  32'(e.mr));
      check("mem_w_en",  32'(bus.mem_w_en),  32'(e.mw));
      check("sr",        32'(bus.sr),        32'(e.sr));
      if (e.dchk) begin
         check("alu_result", bus.alu_result, e.res);
         check("st_val",     bus.st_val,     e.st);
         check("dest",       32'(bus.dest),  32'(e.dest));
      end
   endtask

   task automatic step(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] st, input logic [3:0] d,
                       input logic wb, input logic mr, input logic mw, input logic vld,
                       input logic frz, input logic fl);
      logic [35:0] r;
      exp_t        e;
      @(negedge clk);
      bus.exe_cmd = cmd;  bus.s_bit = s;     bus.val_1 = a;       bus.val_2 = b;
      bus.st_val_in = st; bus.dest_in = d;   bus.wb_en_in = wb;   bus.mem_r_en_in = mr;
      bus.mem_w_en_in = mw; bus.in_valid = vld; bus.freeze = frz; bus.flush = fl;
      r = model_alu(cmd, a, b, m.sr);
      if (!frz) begin
         if (fl) begin
            m.v = 1'b0; m.wb = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.dchk = 1'b0;
         end else begin
            m.v = vld; m.res = r[35:4]; m.st = st; m.dest = d;
            m.wb = wb & vld; m.mr = mr & vld; m.mw = mw & vld; m.dchk = 1'b1;
            if (vld && s && !mr && !mw) m.sr = r[3:0];
         end
      end
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard: observed empty expected entry");
      end else begin
         e = sb_q.pop_front();
         compare_out(e);
      end
   endtask

   task automatic alu_op(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
      step(cmd, s, a, b, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
      check({tag, "_res"},   bus.alu_result,     32'h0);
      check({tag, "_st"},    bus.st_val,         32'h0);
      check({tag, "_ctl"},   32'({bus.dest, bus.wb_en, bus.mem_r_en, bus.mem_w_en}), 32'h0);
      check({tag, "_sr"},    32'(bus.sr),        32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m = '0;
      rst_n = 1'b0;
      bus.exe_cmd = 4'h0; bus.s_bit = 1'b0; bus.val_1 = 32'h0; bus.val_2 = 32'h0;
      bus.st_val_in = 32'h0; bus.dest_in = 4'h0; bus.wb_en_in = 1'b0;
      bus.mem_r_en_in = 1'b0; bus.mem_w_en_in = 1'b0; bus.in_valid = 1'b0;
      bus.freeze = 1'b0; bus.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("rst0");
      @(negedge clk);
      rst_n = 1'b1;

      alu_op(4'b0010, 1'b1, 32'h7FFFFFFF, 32'h1);
      check("add_ovf_res", bus.alu_result, 32'h80000000);
      check("add_ovf_sr",  32'(bus.sr),    32'h9);

      alu_op(4'b0100, 1'b1, 32'd5, 32'd5);
      check("cmp_sr", 32'(bus.sr), 32'h6);
      alu_op(4'b0101, 1'b1, 32'd10, 32'd3);
      check("sbc_res", bus.alu_result, 32'd7);
      check("sbc_sr",  32'(bus.sr),    32'h2);

      alu_op(4'b0010, 1'b1, 32'hFFFFFFFF, 32'h1);
      check("addc_sr", 32'(bus.sr), 32'h6);
      alu_op(4'b0011, 1'b1, 32'd2, 32'd3);
      check("adc_res", bus.alu_result, 32'd6);

      alu_op(4'b0100, 1'b1, 32'd3, 32'd10);
      alu_op(4'b0101, 1'b1, 32'd20, 32'd5);
      alu_op(4'b0101, 1'b1, 32'h80000000, 32'h1);

      alu_op(4'b1001, 1'b1, 32'h0, 32'h0);
      alu_op(4'b0110, 1'b1, 32'hF0F0F0F0, 32'h0F0F0F0F);
      alu_op(4'b0111, 1'b0, 32'h12340000, 32'h00005678);
      alu_op(4'b1000, 1'b1, 32'hFFFF0000, 32'h0F0F0F0F);
      alu_op(4'b1111, 1'b1, 32'h1234, 32'h5678);
      step(4'b0010, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3)
         step(4'b0001, 1'b1, 32'h0, 32'hA5, 32'h11, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(4'b0001, 1'b1, 32'h0, 32'hA5, 32'h11, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("frz_rel_res", bus.alu_result, 32'hA5);

      step(4'b0100, 1'b1, 32'd1, 32'd2, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      check("flush_wb", 32'(bus.wb_en), 32'h0);
      alu_op(4'b0001, 1'b0, 32'h0, 32'h55);
      step(4'b0100, 1'b1, 32'd1, 32'd2, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("frzfl_valid", 32'(bus.out_valid), 32'h1);

      step(4'b0010, 1'b1, 32'h100, 32'h8, 32'hDEAD, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      check("st_addr", bus.alu_result, 32'h108);
      check("st_data", bus.st_val,     32'hDEAD);
      step(4'b0010, 1'b1, 32'hFFFFFFFF, 32'h8, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] c;
         c = 4'($urandom_range(1, 9));
         step(c, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
              1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 7) == 0));
      end

      step(4'b0100, 1'b1, 32'd1, 32'd2, 32'h77, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(4'b0001, 1'b1, 32'h0, 32'h3, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("rst_mid");
      m = '0;
      @(negedge clk);
      bus.freeze = 1'b0;
      rst_n = 1'b1;
      alu_op(4'b0011, 1'b1, 32'd2, 32'd3);
      check("adc_post_rst", bus.alu_result, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
